version_reporter: RTL and testbench

//   Reader side of the build version constants. On a request pulse, streams the version and

---
 rtl/version_report_pkg.sv | 31 +++
 rtl/ver_cksum_acc.sv | 35 +++
 rtl/version_reporter.sv | 145 ++++++++++++++
 tb/tb_version_reporter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/version_report_pkg.sv
// Shared types and constants for the build-version frame reporter.
// build_record() packs the build constants into the 88-bit payload, MSB byte first.
package version_report_pkg;

  typedef enum logic [2:0] {IDLE, SYNC, LEN, PAYLOAD, CKSUM} state_e;
  typedef logic [7:0] byte_t;

  localparam byte_t C_SYNC_DEFAULT = 8'hA5;
  localparam int    C_PAYLOAD_LEN  = 11;
  localparam int    C_FRAME_LEN    = 14;
  localparam int    C_RECORD_W     = 8 * C_PAYLOAD_LEN;

  // Build constants, regenerated by the release flow
  localparam logic [7:0]  C_VERSION_MAJOR  = 8'd1;
  localparam logic [7:0]  C_VERSION_MINOR  = 8'd0;
  localparam logic [7:0]  C_VERSION_PATCH  = 8'd0;
  localparam logic [7:0]  C_VERSION_BUILD  = 8'd1;
  localparam logic [15:0] C_VERSION_YEAR   = 16'd2025;
  localparam logic [7:0]  C_VERSION_MONTH  = 8'd1;
  localparam logic [7:0]  C_VERSION_DAY    = 8'd1;
  localparam logic [7:0]  C_VERSION_HOUR   = 8'd0;
  localparam logic [7:0]  C_VERSION_MINUTE = 8'd0;
  localparam logic [7:0]  C_VERSION_SECOND = 8'd0;

  function automatic logic [C_RECORD_W-1:0] build_record();
    return {C_VERSION_MAJOR, C_VERSION_MINOR, C_VERSION_PATCH, C_VERSION_BUILD,
            C_VERSION_YEAR, C_VERSION_MONTH, C_VERSION_DAY,
            C_VERSION_HOUR, C_VERSION_MINUTE, C_VERSION_SECOND};
  endfunction

endpackage

// File: rtl/ver_cksum_acc.sv
// Modulo-256 running sum of the LEN and payload bytes of a frame.
// cksum_o is the two's complement of the sum including the byte added this cycle.
module ver_cksum_acc
  import version_report_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr_i,
  input  logic  add_i,
  input  byte_t byte_i,
  output byte_t cksum_o
);

  byte_t sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = 8'h00;
    end else if (add_i) begin
      sum_d = sum_q + byte_i;
    end
  end

  assign cksum_o = 8'h00 - sum_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/version_reporter.sv
// Streams the version/build-timestamp record as one framed byte packet per request
// over a registered valid/ready byte interface: SYNC, LEN, payload, CKSUM.
module version_reporter
  import version_report_pkg::*;
#(
  parameter logic [7:0]            P_SYNC   = C_SYNC_DEFAULT,
  parameter logic [C_RECORD_W-1:0] P_RECORD = build_record()
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_i,
  output logic       busy_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       tx_last_o,
  output logic       done_o
);

  localparam logic [3:0] C_LAST_IDX = 4'(C_PAYLOAD_LEN - 1);

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       pending_q, pending_d;
  byte_t      data_q, data_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       hs, start, acc_add;
  byte_t      cksum;

  function automatic byte_t record_byte(input logic [3:0] idx);
    return P_RECORD[C_RECORD_W - 1 - 8 * int'(idx) -: 8];
  endfunction

  assign hs = valid_q & tx_ready_i;
  // A frame starts from IDLE, or back to back when a request is queued at the CKSUM beat
  assign start = ((state_q == IDLE) && req_i) ||
                 ((state_q == CKSUM) && hs && (pending_q || req_i));

  ver_cksum_acc u_cksum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (start),
    .add_i   (acc_add),
    .byte_i  (data_q),
    .cksum_o (cksum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_i) state_d = SYNC;
      SYNC:    if (hs) state_d = LEN;
      LEN:     if (hs) state_d = PAYLOAD;
      PAYLOAD: if (hs && (idx_q == C_LAST_IDX)) state_d = CKSUM;
      CKSUM:   if (hs) state_d = (pending_q || req_i) ? SYNC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next beat is loaded on the handshake of the current one, so outputs stay registered
  always_comb begin
    idx_d     = idx_q;
    pending_d = pending_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    done_d    = 1'b0;
    acc_add   = 1'b0;
    if (hs) begin
      case (state_q)
        SYNC: data_d = 8'(C_PAYLOAD_LEN);
        LEN: begin
          acc_add = 1'b1;
          data_d  = record_byte(4'd0);
        end
        PAYLOAD: begin
          acc_add = 1'b1;
          if (idx_q == C_LAST_IDX) begin
            data_d = cksum;
            last_d = 1'b1;
          end else begin
            idx_d  = idx_q + 4'd1;
            data_d = record_byte(idx_q + 4'd1);
          end
        end
        CKSUM: begin
          done_d  = 1'b1;
          valid_d = 1'b0;
          last_d  = 1'b0;
          data_d  = 8'h00;
        end
        default: ;
      endcase
    end
    if (start) begin
      idx_d     = 4'd0;
      data_d    = P_SYNC;
      valid_d   = 1'b1;
      last_d    = 1'b0;
      pending_d = 1'b0;
    end else if ((state_q != IDLE) && req_i) begin
      pending_d = 1'b1;
    end
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= 4'd0;
      pending_q <= 1'b0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      pending_q <= pending_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy_o     = busy_q;
  assign tx_data_o  = data_q;
  assign tx_valid_o = valid_q;
  assign tx_last_o  = last_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_version_reporter.sv
// Bench for version_reporter: two instances (test record and all-0xFF record) checked every
// cycle against a frame-level reference model, plus literal expectations for the test frame.
module tb_version_reporter;

  localparam logic [87:0] REC0 = 88'h00_00_00_41_20_25_11_10_11_22_55;
  localparam logic [87:0] REC1 = {11{8'hFF}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] req, ready, busy, valid, last, done;
  logic [1:0] rmode;
  logic [7:0] data [2];

  version_reporter #(.P_RECORD(REC0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_i(req[0]), .busy_o(busy[0]), .tx_data_o(data[0]),
    .tx_valid_o(valid[0]), .tx_ready_i(ready[0]), .tx_last_o(last[0]), .done_o(done[0]));

  version_reporter #(.P_RECORD(REC1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_i(req[1]), .busy_o(busy[1]), .tx_data_o(data[1]),
    .tx_valid_o(valid[1]), .tx_ready_i(ready[1]), .tx_last_o(last[1]), .done_o(done[1]));

  logic [7:0] lit [14] = '{8'hA5, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h41, 8'h20,
                           8'h25, 8'h11, 8'h10, 8'h11, 8'h22, 8'h55, 8'hC6};

  logic [7:0] frame [2][14];
  int         m_pos [2] = '{-1, -1};
  bit         m_pend [2];
  bit         m_done [2];
  int         done_cnt [2];
  int         cyc;
  logic [7:0] cap0 [$];
  logic [7:0] cap1 [$];
  int         capc0 [$];
  int         passed = 0;
  int         total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic void build_frame(input int i, input logic [87:0] rec);
    int sum;
    sum = 11;
    frame[i][0] = 8'hA5;
    frame[i][1] = 8'h0B;
    for (int k = 0; k < 11; k++) begin
      frame[i][2 + k] = rec[87 - 8 * k -: 8];
      sum += int'(rec[87 - 8 * k -: 8]);
    end
    frame[i][13] = 8'((256 - sum % 256) % 256);
  endfunction

  // Frame-level reference: each instance either idles or presents beat m_pos of its frame
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        chk("rst_valid", 32'(valid[i]), 0);
        chk("rst_busy", 32'(busy[i]), 0);
        chk("rst_last", 32'(last[i]), 0);
        chk("rst_done", 32'(done[i]), 0);
        chk("rst_data", 32'(data[i]), 0);
        m_pos[i]  = -1;
        m_pend[i] = 1'b0;
        m_done[i] = 1'b0;
      end else begin
        bit active, hs;
        active = (m_pos[i] >= 0);
        chk("valid", 32'(valid[i]), 32'(active));
        chk("busy", 32'(busy[i]), 32'(active));
        chk("done", 32'(done[i]), 32'(m_done[i]));
        if (active) begin
          chk("data", 32'(data[i]), 32'(frame[i][m_pos[i]]));
          chk("last", 32'(last[i]), 32'(m_pos[i] == 13));
        end
        if (done[i]) done_cnt[i]++;
        hs = active && ready[i];
        if (hs) begin
          if (i == 0) begin
            cap0.push_back(data[0]);
            capc0.push_back(cyc);
          end else begin
            cap1.push_back(data[1]);
          end
        end
        m_done[i] = hs && (m_pos[i] == 13);
        if (!active) begin
          if (req[i]) m_pos[i] = 0;
        end else if (hs && m_pos[i] == 13) begin
          if (m_pend[i] || req[i]) begin
            m_pos[i]  = 0;
            m_pend[i] = 1'b0;
          end else begin
            m_pos[i] = -1;
          end
        end else begin
          if (hs) m_pos[i]++;
          if (req[i]) m_pend[i] = 1'b1;
        end
      end
    end
    cyc++;
  end

  initial begin
    ready = 2'b11;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++)
        ready[i] = rmode[i] ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int i);
    req[i] = 1'b1;
    step();
    req[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int budget);
    int n;
    n = 0;
    while (busy[i] && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk("wait_idle_timeout", 32'(busy[i]), 0);
    repeat (2) step();
  endtask

  task automatic check_frame0(input string nm, input int base);
    chk({nm, "_size"}, 32'(cap0.size() >= base + 14), 1);
    if (cap0.size() >= base + 14)
      for (int k = 0; k < 14; k++) chk(nm, 32'(cap0[base + k]), 32'(lit[k]));
  endtask

  initial begin
    int d0, n;
    bit dropped;
    rst_n = 1'b0;
    req   = 2'b00;
    rmode = 2'b00;
    build_frame(0, REC0);
    build_frame(1, REC1);
    for (int k = 0; k < 14; k++) chk("model_frame", 32'(frame[0][k]), 32'(lit[k]));
    chk("model_ff_cksum", 32'(frame[1][13]), 32'h00);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // 1: single frame, ready held high
    cap0.delete(); capc0.delete(); d0 = done_cnt[0];
    pulse(0);
    wait_idle(0, 100);
    chk("t1_beats", cap0.size(), 14);
    check_frame0("t1_byte", 0);
    if (capc0.size() == 14) chk("t1_consecutive", 32'(capc0[13] - capc0[0]), 13);
    chk("t1_done", 32'(done_cnt[0] - d0), 1);

    // 2: random backpressure
    rmode[0] = 1'b1;
    cap0.delete(); d0 = done_cnt[0];
    pulse(0);
    wait_idle(0, 600);
    rmode[0] = 1'b0;
    chk("t2_beats", cap0.size(), 14);
    check_frame0("t2_byte", 0);
    chk("t2_done", 32'(done_cnt[0] - d0), 1);

    // 3: three requests during a frame collapse into one extra frame
    cap0.delete(); capc0.delete(); d0 = done_cnt[0];
    pulse(0);
    step();
    for (int k = 0; k < 3; k++) begin
      pulse(0);
      step();
    end
    wait_idle(0, 100);
    chk("t3_beats", cap0.size(), 28);
    check_frame0("t3_f1", 0);
    check_frame0("t3_f2", 14);
    if (capc0.size() == 28) chk("t3_adjacent", 32'(capc0[14] - capc0[13]), 1);
    chk("t3_done", 32'(done_cnt[0] - d0), 2);

    // 4: request coincident with the CKSUM handshake
    cap0.delete(); d0 = done_cnt[0]; dropped = 1'b0; n = 0;
    pulse(0);
    while (!(valid[0] && last[0]) && n < 50) begin
      step();
      n++;
    end
    chk("t4_reach_last", 32'(valid[0] && last[0]), 1);
    req[0] = 1'b1;
    step();
    req[0] = 1'b0;
    n = 0;
    while (cap0.size() < 27 && n < 100) begin
      if (!busy[0]) dropped = 1'b1;
      step();
      n++;
    end
    wait_idle(0, 100);
    chk("t4_busy_held", 32'(dropped), 0);
    check_frame0("t4_f1", 0);
    check_frame0("t4_f2", 14);
    chk("t4_done", 32'(done_cnt[0] - d0), 2);

    // 5: reset mid-frame aborts, then a clean frame
    cap0.delete(); d0 = done_cnt[0]; n = 0;
    pulse(0);
    while (cap0.size() < 5 && n < 50) begin
      step();
      n++;
    end
    rst_n = 1'b0;
    #1;
    chk("t5_valid_abort", 32'(valid[0]), 0);
    chk("t5_busy_abort", 32'(busy[0]), 0);
    req[0] = 1'b1;
    repeat (3) step();
    req[0] = 1'b0;
    rst_n = 1'b1;
    step();
    step();
    chk("t5_no_done", 32'(done_cnt[0] - d0), 0);
    chk("t5_idle", 32'(busy[0]), 0);
    cap0.delete(); d0 = done_cnt[0];
    pulse(0);
    wait_idle(0, 100);
    chk("t5_beats", cap0.size(), 14);
    check_frame0("t5_byte", 0);
    chk("t5_done", 32'(done_cnt[0] - d0), 1);

    // 6: all-0xFF record, checksum wraps to zero
    rmode[1] = 1'b1;
    cap1.delete(); d0 = done_cnt[1];
    pulse(1);
    wait_idle(1, 600);
    chk("t6_beats", cap1.size(), 14);
    if (cap1.size() == 14) begin
      chk("t6_sync", 32'(cap1[0]), 32'hA5);
      chk("t6_len", 32'(cap1[1]), 32'h0B);
      for (int k = 2; k < 13; k++) chk("t6_payload", 32'(cap1[k]), 32'hFF);
      chk("t6_cksum", 32'(cap1[13]), 32'h00);
    end
    chk("t6_done", 32'(done_cnt[1] - d0), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
